// File: rtl/led_level_meter.sv
// Peak-hold LED level meter: eight signed channels share one time-multiplexed
// magnitude/peak/hold/decay datapath, one channel per clock after each sample strobe.
module led_level_meter #(
  parameter int W            = 16,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                clk_256fs,
  input  logic                rst_n,
  input  logic                clk_fs,
  input  logic                clear,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic signed [W-1:0] in4,
  input  logic signed [W-1:0] in5,
  input  logic signed [W-1:0] in6,
  input  logic signed [W-1:0] in7,
  output logic        [7:0]   led0,
  output logic        [7:0]   led1,
  output logic        [7:0]   led2,
  output logic        [7:0]   led3,
  output logic        [7:0]   led4,
  output logic        [7:0]   led5,
  output logic        [7:0]   led6,
  output logic        [7:0]   led7,
  output logic                update,
  output logic                overrun
);
  localparam int HW = ($clog2(HOLD_SAMPLES + 1) < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_SAMPLES);
  localparam logic [W:0]    MAG_MAX = (W+1)'((1 << (W-1)) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   s1_q, s1_d, s2_q, s2_d, d_q, d_d, stb_q, stb_d;
  logic [2:0]             ch_q, ch_d;
  logic [7:0][W-1:0]      snap_q, snap_d;
  logic [7:0][6:0]        peak_q, peak_d;
  logic [7:0][HW-1:0]     hold_q, hold_d;
  logic [7:0]             pend_q, pend_d;
  logic                   overrun_q, overrun_d;
  logic [6:0]             lvl, pk;
  logic [HW-1:0]          hd;

  // |x| in W+1 bits so the most negative code is representable before saturating.
  function automatic logic [6:0] level_of(input logic [W-1:0] x);
    logic signed [W:0] sx;
    logic        [W:0] mag;
    sx  = {x[W-1], x};
    mag = sx[W] ? $unsigned(-sx) : $unsigned(sx);
    if (mag > MAG_MAX) mag = MAG_MAX;
    return mag[W-2:W-8];
  endfunction

  function automatic logic [6:0] decay_of(input logic [6:0] p);
    logic [6:0] dec;
    dec = p >> DECAY_SHIFT;
    if (dec == 7'd0) dec = 7'd1;
    return (p > dec) ? p - dec : 7'd0;
  endfunction

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      d_q       <= 1'b0;
      stb_q     <= 1'b0;
      ch_q      <= '0;
      snap_q    <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      d_q       <= d_d;
      stb_q     <= stb_d;
      ch_q      <= ch_d;
      snap_q    <= snap_d;
      peak_q    <= peak_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stb_q) state_d = RUN;
      RUN:     if (ch_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    update = (state_q == DONE);
  end

  always_comb begin
    s1_d      = clk_fs;
    s2_d      = s1_q;
    d_d       = s2_q;
    stb_d     = s2_q & ~d_q;
    snap_d    = snap_q;
    peak_d    = peak_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    ch_d      = ch_q;
    overrun_d = overrun_q | (stb_q & (state_q != IDLE));
    lvl       = level_of(snap_q[ch_q]);
    pk        = peak_q[ch_q];
    hd        = hold_q[ch_q];

    if (state_q == IDLE && stb_q) begin
      snap_d = {in7, in6, in5, in4, in3, in2, in1, in0};
      ch_d   = '0;
    end

    if (state_q == RUN) begin
      ch_d = ch_q + 3'd1;
      if (clear || pend_q[ch_q]) begin
        pk = '0;
        hd = '0;
      end else if (lvl >= pk) begin
        pk = lvl;
        hd = HOLD_LD;
      end else if (hd != '0) begin
        hd = hd - HW'(1);
      end else begin
        pk = decay_of(pk);
      end
      peak_d[ch_q] = pk;
      hold_d[ch_q] = hd;
      pend_d[ch_q] = 1'b0;
      // Mid-pass clear: later channels clear as they come up, earlier ones on the next pass.
      if (clear) begin
        pend_d       = '1;
        pend_d[ch_q] = 1'b0;
      end
    end else if (clear) begin
      peak_d = '0;
      hold_d = '0;
      pend_d = '0;
    end
  end

  assign overrun = overrun_q;
  assign led0    = {1'b0, peak_q[0]};
  assign led1    = {1'b0, peak_q[1]};
  assign led2    = {1'b0, peak_q[2]};
  assign led3    = {1'b0, peak_q[3]};
  assign led4    = {1'b0, peak_q[4]};
  assign led5    = {1'b0, peak_q[5]};
  assign led6    = {1'b0, peak_q[6]};
  assign led7    = {1'b0, peak_q[7]};

endmodule

// File: tb/tb_led_level_meter.sv
// Bench for led_level_meter: table of per-pass vectors checked through an
// expected-LED queue on each update pulse, plus hand sequences for timing corners.
module tb_led_level_meter;
  typedef logic [7:0][7:0]  leds_t;
  typedef logic [7:0][15:0] ins_t;
  typedef struct {
    ins_t  vin;
    leds_t exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n, clk_fs, clear;
  logic signed [15:0] in_v [8];
  logic        [7:0]  led_w [8];
  logic               update, overrun;

  int    errors = 0;
  int    checks = 0;
  leds_t exp_q[$];
  vec_t  tbl[6];

  led_level_meter #(.W(16), .HOLD_SAMPLES(2), .DECAY_SHIFT(4)) dut (
    .clk_256fs(clk), .rst_n(rst_n), .clk_fs(clk_fs), .clear(clear),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .led0(led_w[0]), .led1(led_w[1]), .led2(led_w[2]), .led3(led_w[3]),
    .led4(led_w[4]), .led5(led_w[5]), .led6(led_w[6]), .led7(led_w[7]),
    .update(update), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && update) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        leds_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++)
          check($sformatf("pass_led%0d", k), int'(led_w[k]), int'(e[k]));
      end
    end
  end

  function automatic leds_t one_led(input int k, input logic [7:0] val);
    leds_t r;
    r    = '0;
    r[k] = val;
    return r;
  endfunction

  function automatic ins_t one_in(input int k, input logic [15:0] val);
    ins_t r;
    r    = '0;
    r[k] = val;
    return r;
  endfunction

  function automatic int dstep(input int p);
    int d;
    d = p >> 4;
    if (d < 1) d = 1;
    return (p > d) ? p - d : 0;
  endfunction

  task automatic run_pass(input ins_t v, input leds_t e);
    @(negedge clk);
    for (int k = 0; k < 8; k++) in_v[k] = v[k];
    exp_q.push_back(e);
    clk_fs = 1'b1;
    repeat (10) @(negedge clk);
    clk_fs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_led, upd_at, upd_cnt, other_nz, p;

    // in7..in0 / led7..led0 (HOLD_SAMPLES=2, DECAY_SHIFT=4)
    tbl[0].vin = {16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h4000};
    tbl[0].exp = {8'd0, 8'd0, 8'd1, 8'd0, 8'd127, 8'd0, 8'd0, 8'd64};
    tbl[1].vin = {8{16'h0100}};
    tbl[1].exp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd127, 8'd1, 8'd1, 8'd64};
    tbl[2].vin = '0;
    tbl[2].exp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd127, 8'd1, 8'd1, 8'd64};
    tbl[3].vin = '0;
    tbl[3].exp = {8'd1, 8'd1, 8'd1, 8'd1, 8'd120, 8'd1, 8'd1, 8'd60};
    tbl[4].vin = {16'h7FFF, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].exp = {8'd127, 8'd16, 8'd0, 8'd0, 8'd113, 8'd0, 8'd0, 8'd57};
    tbl[5].vin = {16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0200, 16'h0000, 16'h0000};
    tbl[5].exp = {8'd127, 8'd16, 8'd0, 8'd0, 8'd106, 8'd2, 8'd0, 8'd54};

    rst_n = 1'b0; clk_fs = 1'b0; clear = 1'b0;
    for (int k = 0; k < 8; k++) in_v[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) check($sformatf("reset_led%0d", k), int'(led_w[k]), 0);
    check("reset_update", int'(update), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_pass(tbl[i].vin, tbl[i].exp);
    check("no_overrun_normal", int'(overrun), 0);

    // Async reset in the middle of a pass
    @(negedge clk);
    clk_fs = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_led0", int'(led_w[0]), 0);
    check("midrun_rst_led7", int'(led_w[7]), 0);
    check("midrun_rst_update", int'(update), 0);
    check("midrun_rst_overrun", int'(overrun), 0);
    clk_fs = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    upd_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (update) upd_cnt++;
    end
    check("idle_after_rst", upd_cnt, 0);

    // Latency: led0 from S+2, update only in S+9
    for (int k = 0; k < 8; k++) in_v[k] = '0;
    in_v[0] = 16'sh4000;
    exp_q.push_back(one_led(0, 8'd64));
    clk_fs = 1'b1;
    first_led = 0; upd_at = 0; upd_cnt = 0; other_nz = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (first_led == 0 && led_w[0] == 8'd64) first_led = i;
      if (update) begin upd_cnt++; upd_at = i; end
      for (int k = 1; k < 8; k++) if (led_w[k] != 8'd0) other_nz = 1;
      if (i == 10) clk_fs = 1'b0;
    end
    check("lat_led0_cycle", first_led, 5);
    check("lat_update_cycle", upd_at, 12);
    check("lat_update_count", upd_cnt, 1);
    check("lat_others_zero", other_nz, 0);

    // Positive 256 reads the same level as -256
    do_reset();
    run_pass(one_in(5, 16'h0100), one_led(5, 8'd1));

    // Hold then decay down to zero
    do_reset();
    run_pass(one_in(0, 16'h7FFF), one_led(0, 8'd127));
    run_pass('0, one_led(0, 8'd127));
    run_pass('0, one_led(0, 8'd127));
    p = 127;
    for (int i = 0; i < 64; i++) begin
      p = dstep(p);
      run_pass('0, one_led(0, 8'(p)));
    end

    // Overrun: second edge lands in cycle S+5
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 8; k++) in_v[k] = '0;
    in_v[0] = 16'sh1000;
    exp_q.push_back(one_led(0, 8'd16));
    clk_fs = 1'b1;
    repeat (2) @(negedge clk);
    clk_fs = 1'b0;
    repeat (3) @(negedge clk);
    clk_fs = 1'b1;
    upd_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (update) upd_cnt++;
    end
    clk_fs = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_update_count", upd_cnt, 1);
    check("ovr_set", int'(overrun), 1);
    run_pass(one_in(0, 16'h1000), one_led(0, 8'd16));
    check("ovr_sticky", int'(overrun), 1);

    // Clear held across passes, then a fresh capture
    run_pass({8{16'h4000}}, {8{8'd64}});
    clear = 1'b1;
    repeat (15) run_pass({8{16'h4000}}, '0);
    clear = 1'b0;
    run_pass(one_in(2, 16'h2000), one_led(2, 8'd32));

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
